// File: rtl/usb_cmd_frame_parser.sv
// Host command frame parser: syncs on HDR0/HDR1, buffers the payload, verifies the
// modulo-256 checksum and streams each good frame to one of NUM_CMDS handler channels.
module usb_cmd_frame_parser #(
  parameter logic [7:0] HDR0        = 8'hAA,
  parameter logic [7:0] HDR1        = 8'h55,
  parameter logic [7:0] CMD_BASE    = 8'h00,
  parameter int         NUM_CMDS    = 16,
  parameter int         MAX_LEN     = 128,
  parameter int         TIMEOUT_CYC = 60000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          usb_data_in,
  input  logic                usb_data_valid_in,
  output logic [NUM_CMDS-1:0] cmd_sel,
  output logic [7:0]          cmd_code,
  output logic [15:0]         cmd_len,
  output logic                cmd_start,
  output logic [7:0]          cmd_data,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_last,
  output logic                cmd_done,
  output logic                err_checksum,
  output logic                err_len,
  output logic                err_timeout,
  output logic                err_unknown,
  output logic                err_overrun,
  output logic                busy
);

  localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0]     MAX_LEN_L = 16'(MAX_LEN);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_CMD, S_LENH, S_LENL, S_PAYLOAD, S_CHK, S_DISPATCH, S_STREAM
  } state_t;

  state_t              state_reg, state_next;
  logic [7:0]          code_reg, code_next;
  logic [15:0]         len_reg, len_next;
  logic [7:0]          sum_reg, sum_next;
  logic [15:0]         wr_cnt_reg, wr_cnt_next;
  logic [15:0]         rd_idx_reg, rd_idx_next;
  logic [TW-1:0]       tmo_reg, tmo_next;
  logic [NUM_CMDS-1:0] sel_reg, sel_next;
  logic [7:0]          out_code_reg, out_code_next;
  logic [15:0]         out_len_reg, out_len_next;
  logic                start_reg, start_next;
  logic                valid_reg, valid_next;
  logic                done_reg, done_next;
  logic                err_chk_reg, err_chk_next;
  logic                err_len_reg, err_len_next;
  logic                err_tmo_reg, err_tmo_next;
  logic                err_unk_reg, err_unk_next;
  logic                err_ovr_reg, err_ovr_next;

  logic [7:0]          mem [MAX_LEN];
  logic [7:0]          rd_data;
  logic                wr_en, rd_en;
  logic [AW-1:0]       wr_addr, rd_addr;

  logic [7:0]          code_off;
  logic [NUM_CMDS-1:0] sel_dec;
  logic                code_in_range;
  logic [15:0]         len_new;
  logic                in_frame;
  logic                tmo_hit;

  // One comparator per channel; a code outside the window hits none of them.
  assign code_off = code_reg - CMD_BASE;
  for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_dec
    assign sel_dec[gi] = (code_off == 8'(gi));
  end
  assign code_in_range = |sel_dec;

  assign len_new  = {len_reg[15:8], usb_data_in};
  assign in_frame = (state_reg inside {S_SYNC, S_CMD, S_LENH, S_LENL, S_PAYLOAD, S_CHK});
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit  = in_frame && !usb_data_valid_in && (tmo_reg == TMO_LAST);

  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    len_next      = len_reg;
    sum_next      = sum_reg;
    wr_cnt_next   = wr_cnt_reg;
    rd_idx_next   = rd_idx_reg;
    sel_next      = sel_reg;
    out_code_next = out_code_reg;
    out_len_next  = out_len_reg;
    valid_next    = valid_reg;
    start_next    = 1'b0;
    done_next     = 1'b0;
    err_chk_next  = 1'b0;
    err_len_next  = 1'b0;
    err_tmo_next  = 1'b0;
    err_unk_next  = 1'b0;
    err_ovr_next  = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = wr_cnt_reg[AW-1:0];
    rd_en         = 1'b0;
    rd_addr       = '0;
    tmo_next      = (!in_frame || usb_data_valid_in || tmo_hit) ? '0 : tmo_reg + 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (usb_data_valid_in && usb_data_in == HDR0) state_next = S_SYNC;
      end
      S_SYNC: begin
        if (usb_data_valid_in) begin
          if (usb_data_in == HDR1)      state_next = S_CMD;
          else if (usb_data_in == HDR0) state_next = S_SYNC;
          else                          state_next = S_IDLE;
        end
      end
      S_CMD: begin
        if (usb_data_valid_in) begin
          code_next  = usb_data_in;
          sum_next   = usb_data_in;
          state_next = S_LENH;
        end
      end
      S_LENH: begin
        if (usb_data_valid_in) begin
          len_next   = {usb_data_in, len_reg[7:0]};
          sum_next   = sum_reg + usb_data_in;
          state_next = S_LENL;
        end
      end
      S_LENL: begin
        if (usb_data_valid_in) begin
          len_next    = len_new;
          sum_next    = sum_reg + usb_data_in;
          wr_cnt_next = '0;
          if (len_new > MAX_LEN_L) begin
            err_len_next = 1'b1;
            state_next   = S_IDLE;
          end else if (len_new == 16'd0) begin
            state_next = S_CHK;
          end else begin
            state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (usb_data_valid_in) begin
          wr_en       = 1'b1;
          sum_next    = sum_reg + usb_data_in;
          wr_cnt_next = wr_cnt_reg + 16'd1;
          if (wr_cnt_reg + 16'd1 == len_reg) state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (usb_data_valid_in) begin
          if (usb_data_in != sum_reg) begin
            err_chk_next = 1'b1;
            state_next   = S_IDLE;
          end else if (!code_in_range) begin
            err_unk_next = 1'b1;
            state_next   = S_IDLE;
          end else begin
            start_next    = 1'b1;
            sel_next      = sel_dec;
            out_code_next = code_reg;
            out_len_next  = len_reg;
            state_next    = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        if (len_reg == 16'd0) begin
          done_next     = 1'b1;
          sel_next      = '0;
          out_code_next = '0;
          out_len_next  = '0;
          state_next    = S_IDLE;
        end else begin
          // Prefetch byte 0 so it is presented the cycle after cmd_start.
          rd_en       = 1'b1;
          rd_addr     = '0;
          rd_idx_next = '0;
          valid_next  = 1'b1;
          state_next  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (valid_reg && cmd_ready) begin
          if (rd_idx_reg == out_len_reg - 16'd1) begin
            valid_next    = 1'b0;
            done_next     = 1'b1;
            sel_next      = '0;
            out_code_next = '0;
            out_len_next  = '0;
            state_next    = S_IDLE;
          end else begin
            rd_en       = 1'b1;
            rd_addr     = AW'(rd_idx_reg + 16'd1);
            rd_idx_next = rd_idx_reg + 16'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (usb_data_valid_in && (state_reg == S_DISPATCH || state_reg == S_STREAM))
      err_ovr_next = 1'b1;

    if (tmo_hit) begin
      err_tmo_next = 1'b1;
      state_next   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      code_reg     <= '0;
      len_reg      <= '0;
      sum_reg      <= '0;
      wr_cnt_reg   <= '0;
      rd_idx_reg   <= '0;
      tmo_reg      <= '0;
      sel_reg      <= '0;
      out_code_reg <= '0;
      out_len_reg  <= '0;
      start_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
      err_chk_reg  <= 1'b0;
      err_len_reg  <= 1'b0;
      err_tmo_reg  <= 1'b0;
      err_unk_reg  <= 1'b0;
      err_ovr_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      code_reg     <= code_next;
      len_reg      <= len_next;
      sum_reg      <= sum_next;
      wr_cnt_reg   <= wr_cnt_next;
      rd_idx_reg   <= rd_idx_next;
      tmo_reg      <= tmo_next;
      sel_reg      <= sel_next;
      out_code_reg <= out_code_next;
      out_len_reg  <= out_len_next;
      start_reg    <= start_next;
      valid_reg    <= valid_next;
      done_reg     <= done_next;
      err_chk_reg  <= err_chk_next;
      err_len_reg  <= err_len_next;
      err_tmo_reg  <= err_tmo_next;
      err_unk_reg  <= err_unk_next;
      err_ovr_reg  <= err_ovr_next;
    end
  end

  // Payload buffer; the read register only advances on rd_en, so data holds under stall.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= usb_data_in;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  assign cmd_sel      = sel_reg;
  assign cmd_code     = out_code_reg;
  assign cmd_len      = out_len_reg;
  assign cmd_start    = start_reg;
  assign cmd_valid    = valid_reg;
  assign cmd_data     = valid_reg ? rd_data : 8'h00;
  assign cmd_last     = valid_reg && (rd_idx_reg == out_len_reg - 16'd1);
  assign cmd_done     = done_reg;
  assign err_checksum = err_chk_reg;
  assign err_len      = err_len_reg;
  assign err_timeout  = err_tmo_reg;
  assign err_unknown  = err_unk_reg;
  assign err_overrun  = err_ovr_reg;
  assign busy         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Bench for usb_cmd_frame_parser: directed frames plus random frames, each checked
// against a byte-level frame model; a negedge monitor logs DUT events into queues.
module tb_usb_cmd_frame_parser;
  localparam int         NUM_CMDS    = 16;
  localparam int         MAX_LEN     = 128;
  localparam int         TIMEOUT_CYC = 60000;
  localparam logic [7:0] CMD_BASE    = 8'h00;
  localparam int K_NONE = 0, K_DISP = 1, K_CHK = 2, K_LEN = 3, K_UNK = 4;

  typedef logic [7:0] bq_t[$];

  logic                clk = 1'b0;
  logic                rst_n;
  logic [7:0]          usb_data_in;
  logic                usb_data_valid_in;
  logic [NUM_CMDS-1:0] cmd_sel;
  logic [7:0]          cmd_code;
  logic [15:0]         cmd_len;
  logic                cmd_start;
  logic [7:0]          cmd_data;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_last;
  logic                cmd_done;
  logic                err_checksum, err_len, err_timeout, err_unknown, err_overrun;
  logic                busy;

  usb_cmd_frame_parser #(
    .HDR0(8'hAA), .HDR1(8'h55), .CMD_BASE(CMD_BASE), .NUM_CMDS(NUM_CMDS),
    .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .usb_data_in(usb_data_in), .usb_data_valid_in(usb_data_valid_in),
    .cmd_sel(cmd_sel), .cmd_code(cmd_code), .cmd_len(cmd_len), .cmd_start(cmd_start),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_last(cmd_last),
    .cmd_done(cmd_done), .err_checksum(err_checksum), .err_len(err_len),
    .err_timeout(err_timeout), .err_unknown(err_unknown), .err_overrun(err_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;

  // Handler-side ready pattern: 0 always, 1 toggle, 2 random, 3 stalled.
  initial begin
    cmd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = ~cmd_ready;
        2:       cmd_ready = 1'($urandom_range(0, 1));
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  int cyc = 0, cnt_start = 0, cnt_done = 0, cnt_chk = 0, cnt_len = 0, cnt_tmo = 0;
  int cnt_unk = 0, cnt_ovr = 0, cnt_vcyc = 0, hold_viol = 0, start_valid = 0, sel_viol = 0;
  int start_cyc = 0, done_cyc = 0, hs_cyc = 0;
  logic [15:0] q_sel[$];
  logic [7:0]  q_code[$];
  logic [15:0] q_len[$];
  logic [7:0]  q_data[$];
  logic        q_last[$];
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0]  pd = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (cmd_start) begin
        cnt_start++; start_cyc = cyc;
        q_sel.push_back(cmd_sel); q_code.push_back(cmd_code); q_len.push_back(cmd_len);
        if (cmd_valid) start_valid++;
      end
      if (cmd_done)     begin cnt_done++; done_cyc = cyc; end
      if (err_checksum) cnt_chk++;
      if (err_len)      cnt_len++;
      if (err_timeout)  cnt_tmo++;
      if (err_unknown)  cnt_unk++;
      if (err_overrun)  cnt_ovr++;
      if (cmd_valid)    cnt_vcyc++;
      if (cmd_valid && cmd_sel == '0) sel_viol++;
      if (pv && !pr && !(cmd_valid && cmd_data == pd && cmd_last == pl)) hold_viol++;
      if (cmd_valid && cmd_ready) begin
        q_data.push_back(cmd_data); q_last.push_back(cmd_last); hs_cyc = cyc;
      end
      pv = cmd_valid; pr = cmd_ready; pd = cmd_data; pl = cmd_last;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    usb_data_in = b; usb_data_valid_in = 1'b1;
    tick();
    usb_data_valid_in = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_q(input bq_t fr, input int gap_max);
    foreach (fr[i]) send_byte(fr[i], int'($urandom_range(0, gap_max)));
  endtask

  int b_start, b_done, b_chk, b_len, b_tmo, b_unk, b_ovr, b_vcyc, b_data;
  task automatic snap();
    b_start = cnt_start; b_done = cnt_done; b_chk = cnt_chk; b_len = cnt_len;
    b_tmo = cnt_tmo; b_unk = cnt_unk; b_ovr = cnt_ovr; b_vcyc = cnt_vcyc; b_data = q_data.size();
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while (busy && n < 5000) begin tick(); n++; end
    check("idle_reached", longint'(busy), 64'd0);
    repeat (2) tick();
  endtask

  // Frame semantics from the byte stream alone: locate AA 55, then judge len/checksum/code.
  task automatic model(input bq_t fr, output int kind, output logic [7:0] code,
                       output logic [15:0] len, output bq_t pay);
    int i = 0;
    int L;
    logic [7:0] sum;
    pay = {}; kind = K_NONE; code = 8'h00; len = 16'h0;
    while (i + 1 < fr.size() && !(fr[i] == 8'hAA && fr[i+1] == 8'h55)) i++;
    if (i + 4 >= fr.size()) return;
    code = fr[i+2];
    len  = {fr[i+3], fr[i+4]};
    L    = int'(len);
    if (L > MAX_LEN) begin kind = K_LEN; return; end
    if (i + 5 + L >= fr.size()) return;
    sum = code + fr[i+3] + fr[i+4];
    for (int k = 0; k < L; k++) begin
      pay.push_back(fr[i+5+k]);
      sum = sum + fr[i+5+k];
    end
    if (fr[i+5+L] != sum)                                               kind = K_CHK;
    else if (int'(code) - int'(CMD_BASE) < 0 ||
             int'(code) - int'(CMD_BASE) >= NUM_CMDS)                   kind = K_UNK;
    else                                                                kind = K_DISP;
  endtask

  task automatic verify(input bq_t fr, input int exp_ovr);
    int kind, nb, L;
    logic [7:0] code;
    logic [15:0] len;
    logic [15:0] exp_sel;
    bq_t pay;
    model(fr, kind, code, len, pay);
    L  = int'(len);
    nb = q_data.size() - b_data;
    $display("frame code=%02h len=%0d kind=%0d bytes_seen=%0d", code, L, kind, nb);
    check("starts", longint'(cnt_start - b_start), longint'(kind == K_DISP));
    check("err_checksum", longint'(cnt_chk - b_chk), longint'(kind == K_CHK));
    check("err_len", longint'(cnt_len - b_len), longint'(kind == K_LEN));
    check("err_unknown", longint'(cnt_unk - b_unk), longint'(kind == K_UNK));
    check("err_timeout", longint'(cnt_tmo - b_tmo), 64'd0);
    check("err_overrun", longint'(cnt_ovr - b_ovr), longint'(exp_ovr));
    check("dones", longint'(cnt_done - b_done), longint'(kind == K_DISP));
    if (kind == K_DISP) begin
      exp_sel = 16'h1 << (code - CMD_BASE);
      check("cmd_sel", longint'(q_sel[b_start]), longint'(exp_sel));
      check("cmd_code", longint'(q_code[b_start]), longint'(code));
      check("cmd_len", longint'(q_len[b_start]), longint'(len));
      check("nbytes", longint'(nb), longint'(L));
      for (int i = 0; i < L && i < nb; i++) begin
        check($sformatf("data[%0d]", i), longint'(q_data[b_data+i]), longint'(pay[i]));
        check($sformatf("last[%0d]", i), longint'(q_last[b_data+i]), longint'(i == L - 1));
      end
      if (L == 0) begin
        check("done_after_start", longint'(done_cyc - start_cyc), 64'd1);
        check("valid_cycles", longint'(cnt_vcyc - b_vcyc), 64'd0);
      end else begin
        check("done_after_last", longint'(done_cyc - hs_cyc), 64'd1);
      end
    end else begin
      check("nbytes", longint'(nb), 64'd0);
    end
    check("hold_stable", longint'(hold_viol), 64'd0);
    check("valid_with_start", longint'(start_valid), 64'd0);
    check("sel_during_valid", longint'(sel_viol), 64'd0);
    check("busy_after", longint'(busy), 64'd0);
  endtask

  task automatic run_frame(input bq_t fr, input int gap_max);
    snap();
    send_q(fr, gap_max);
    wait_idle();
    verify(fr, 0);
  endtask

  initial begin
    bq_t fr, t1, t2, t3;
    int n, len, code;
    logic [7:0] sum;

    rst_n = 1'b0; usb_data_in = 8'h00; usb_data_valid_in = 1'b0;
    repeat (3) tick();
    check("rst_busy", longint'(busy), 64'd0);
    check("rst_sel", longint'(cmd_sel), 64'd0);
    check("rst_code", longint'(cmd_code), 64'd0);
    check("rst_len", longint'(cmd_len), 64'd0);
    check("rst_valid", longint'(cmd_valid), 64'd0);
    check("rst_pulses", longint'({cmd_start, cmd_done, err_checksum, err_len,
                                  err_timeout, err_unknown, err_overrun}), 64'd0);
    rst_n = 1'b1;
    tick();

    t1 = '{8'hAA, 8'h55, 8'h04, 8'h00, 8'h01, 8'h50, 8'h55};
    t2 = '{8'hAA, 8'h55, 8'h05, 8'h00, 8'h06, 8'h00, 8'h3C, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h7F};
    t3 = '{8'hAA, 8'h55, 8'h06, 8'h00, 8'h04, 8'h00, 8'h3C, 8'h00, 8'h04, 8'h4A};

    ready_mode = 0; run_frame(t1, 0);
    ready_mode = 1; run_frame(t2, 0);

    // Stray host byte while streaming
    ready_mode = 1;
    snap();
    send_q(t3, 0);
    n = 0;
    while (q_data.size() == b_data && n < 200) begin tick(); n++; end
    check("first_handshake", longint'(q_data.size() > b_data), 64'd1);
    send_byte(8'hAA, 0);
    wait_idle();
    verify(t3, 1);

    ready_mode = 0;
    fr = '{8'hAA, 8'h55, 8'h04, 8'h00, 8'h01, 8'h50, 8'h54}; run_frame(fr, 1);
    fr = '{8'hAA, 8'h55, 8'h04, 8'h00, 8'hC8};               run_frame(fr, 0);
    run_frame(t1, 2);

    // Inter-byte timeout
    snap();
    fr = '{8'hAA, 8'h55, 8'h05, 8'h00};
    send_q(fr, 0);
    n = 0;
    while (cnt_tmo == b_tmo && n < TIMEOUT_CYC + 2000) begin tick(); n++; end
    $display("timeout frame idle_cycles=%0d", n);
    check("timeout_fired", longint'(cnt_tmo - b_tmo), 64'd1);
    check("timeout_window", longint'(n >= TIMEOUT_CYC && n <= TIMEOUT_CYC + 2), 64'd1);
    check("timeout_busy", longint'(busy), 64'd0);
    check("timeout_no_start", longint'(cnt_start - b_start), 64'd0);
    fr = '{8'hAA, 8'hAA, 8'h55, 8'h04, 8'h00, 8'h01, 8'h50, 8'h55}; run_frame(fr, 0);

    fr = '{8'hAA, 8'h55, 8'h07, 8'h00, 8'h00, 8'h07}; run_frame(fr, 0);
    fr = '{8'hAA, 8'h55, 8'h20, 8'h00, 8'h00, 8'h20}; run_frame(fr, 0);
    fr = '{8'hAA, 8'h55, 8'h0F, 8'h00, 8'h80};
    for (int i = 0; i < 128; i++) fr.push_back(8'(i * 3));
    sum = 8'h0F + 8'h80;
    for (int i = 0; i < 128; i++) sum = sum + 8'(i * 3);
    fr.push_back(sum);
    ready_mode = 2; run_frame(fr, 0);

    for (int t = 0; t < 20; t++) begin
      ready_mode = int'($urandom_range(0, 2));
      code = int'($urandom_range(0, 19));
      n = int'($urandom_range(0, 9));
      len = (n == 0) ? int'($urandom_range(129, 300)) :
            (n == 1) ? 0 : int'($urandom_range(1, 40));
      fr = '{8'hAA, 8'h55, 8'(code), 8'(len >> 8), 8'(len)};
      if (len <= MAX_LEN) begin
        sum = 8'(code) + 8'(len >> 8) + 8'(len);
        for (int i = 0; i < len; i++) begin
          fr.push_back(8'($urandom));
          sum = sum + fr[fr.size()-1];
        end
        if ($urandom_range(0, 5) == 0) sum = sum + 8'($urandom_range(1, 255));
        fr.push_back(sum);
      end
      run_frame(fr, 3);
    end

    // Asynchronous reset while a stream is stalled
    ready_mode = 3;
    fr = '{8'hAA, 8'h55, 8'h03, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6C};
    send_q(fr, 0);
    n = 0;
    while (!cmd_valid && n < 50) begin tick(); n++; end
    check("stream_started", longint'(cmd_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", longint'(cmd_valid), 64'd0);
    check("midrst_sel", longint'(cmd_sel), 64'd0);
    check("midrst_code_len", longint'({cmd_code, cmd_len}), 64'd0);
    check("midrst_busy", longint'(busy), 64'd0);
    check("midrst_data_last", longint'({cmd_data, cmd_last}), 64'd0);
    tick();
    rst_n = 1'b1;
    ready_mode = 0;
    tick();
    run_frame(t1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_cmd_frame_parser.md
Name: usb_cmd_frame_parser

Overview:
- Parametrised successor to the single-purpose USB command decode inside cdc.
- Parses host byte frames of the form HDR0, HDR1, cmd, lenH, lenL, payload[len], checksum.
- Buffers the payload and verifies the 8-bit checksum before committing the frame.
- Dispatches each verified frame to one of NUM_CMDS handler channels (I2C config/write/read, PWM, UART, DAC ...) through a one-hot select and a valid/ready payload stream.

Parameters:
HDR0  8'hAA  first sync byte
HDR1  8'h55  second sync byte
CMD_BASE  8'h00  command code mapped to channel 0
NUM_CMDS  16  number of handler channels; codes CMD_BASE..CMD_BASE+NUM_CMDS-1
MAX_LEN  128  payload buffer depth in bytes; frames with larger len are rejected
TIMEOUT_CYC  60000  idle cycles between bytes inside a frame before abort (1 ms at 60 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
usb_data_in  in  8  host byte
usb_data_valid_in  in  1  single-cycle byte strobe; no backpressure toward host
cmd_sel  out  NUM_CMDS  one-hot channel select, held from cmd_start to cmd_done
cmd_code  out  8  raw command code, held with cmd_sel
cmd_len  out  16  payload length, held with cmd_sel
cmd_start  out  1  one-cycle pulse: verified frame dispatched
cmd_data  out  8  payload byte
cmd_valid  out  1  payload byte valid
cmd_ready  in  1  handler accepts byte
cmd_last  out  1  marks final payload byte (qualified by cmd_valid)
cmd_done  out  1  one-cycle pulse after last byte accepted (or after cmd_start when len=0)
err_checksum  out  1  one-cycle pulse: checksum mismatch, frame discarded
err_len  out  1  one-cycle pulse: len > MAX_LEN, frame discarded
err_timeout  out  1  one-cycle pulse: inter-byte timeout, frame discarded
err_unknown  out  1  one-cycle pulse: checksum good but code out of range, no dispatch
err_overrun  out  1  one-cycle pulse per byte dropped while dispatching
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, any time, including mid-frame or mid-stream): state=IDLE; all outputs 0 except cmd_sel=0, cmd_code=0, cmd_len=0; counters and checksum cleared. Buffer RAM is not cleared.
- State machine and transitions:
  - IDLE: byte==HDR0 -> SYNC; any other byte is ignored.
  - SYNC: byte==HDR1 -> CMD; byte==HDR0 -> stay in SYNC (resync); any other byte -> IDLE.
  - CMD: latch code; sum=code -> LENH.
  - LENH: latch len[15:8]; sum+=byte -> LENL.
  - LENL: latch len[7:0]; sum+=byte. If len>MAX_LEN, pulse err_len next cycle -> IDLE. If len==0 -> CHK. Otherwise -> PAYLOAD.
  - PAYLOAD: write byte to buffer[wr_idx]; sum+=byte; wr_idx++. After len bytes -> CHK.
  - CHK: byte!=sum -> err_checksum -> IDLE. Code outside range -> err_unknown -> IDLE. Otherwise -> DISPATCH.
- Checksum: 8-bit modulo-256 sum of cmd, lenH, lenL and all payload bytes; headers excluded.
- DISPATCH: lasts one cycle. Drives cmd_start=1; cmd_sel bit (code-CMD_BASE)=1; cmd_code and cmd_len valid this same cycle -> STREAM.
- STREAM: buffer read with 1-cycle latency; first cmd_valid no earlier than the cycle after cmd_start.
  - cmd_data and cmd_last hold stable while cmd_valid && !cmd_ready.
  - Each handshake advances rd_idx. Sustained throughput is 1 byte/cycle when cmd_ready stays high.
  - After the last handshake, cmd_done pulses on the next cycle; cmd_sel is cleared on that same cycle -> IDLE.
  - len==0: cmd_done pulses the cycle after cmd_start; cmd_valid is never asserted.
- Host bytes arriving in DISPATCH/STREAM are dropped, with one err_overrun pulse each; parsing restarts from IDLE afterwards.
- Timeout: counter reloads on every usb_data_valid_in. It runs only in states SYNC through CHK. On reaching TIMEOUT_CYC, pulse err_timeout -> IDLE, discarding partial data.
- At most one err_* pulses per frame. A byte strobe in the same cycle as timeout expiry takes precedence: the counter reloads and no timeout occurs.

Test Plan:
1. Config frame AA 55 04 00 01 50 55 with CMD_BASE=0 -> cmd_start with cmd_sel=16'h0010, cmd_len=1; one byte 0x50 with cmd_last=1; cmd_done; no err pulses.
2. Write frame AA 55 05 00 06 00 3C DE AD BE EF 7F; cmd_ready toggles 1/0 each cycle -> cmd_sel bit5; bytes 00,3C,DE,AD,BE,EF in order, each held while unready; cmd_last only on EF; exactly 6 handshakes.
3. Read frame AA 55 06 00 04 00 3C 00 04 4A -> dispatch on bit6, 4 bytes; a stray byte 0xAA injected mid-stream -> one err_overrun, stream unaffected.
4. Config frame with checksum 0x54 -> err_checksum, no cmd_start. Frame AA 55 04 00 C8 (len 200 > 128) -> err_len after the LENL byte. Next valid frame parses normally.
5. Send AA 55 05 00, then idle for 60000 cycles -> err_timeout, busy=0. Byte sequence AA AA 55 04 00 01 50 55 (resync) -> dispatches correctly.
6. Zero-length frame AA 55 07 00 00 07 -> cmd_start then cmd_done next cycle, no cmd_valid. Frame code 0x20 with valid checksum -> err_unknown. Assert rst_n=0 mid-STREAM -> all outputs 0 immediately.
